// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin ALU/LSU grant, registered write port and busy scoreboard.
// Optional macro WB_BYPASS_EN adds same-cycle forwarding of the landing write to the rs1/rs2 lookups.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              write_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
`ifdef WB_BYPASS_EN
  ,
  output logic [DATA_W-1:0] rs1_fwd,
  output logic [DATA_W-1:0] rs2_fwd,
  output logic              rs1_fwd_hit,
  output logic              rs2_fwd_hit
`endif
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};

  logic              alu_gnt_s;
  logic              lsu_gnt_s;
  logic              xfer_s;
  logic [ADDR_W-1:0] sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [NREG-1:0]   busy_nxt_s;
  logic              rs1_busy_s;
  logic              rs2_busy_s;
  logic              rs1_hit_s;
  logic              rs2_hit_s;

  // ptr_r = 1 means the LSU was granted last, so the ALU wins the next contended cycle
  logic              ptr_r;
  logic [NREG-1:0]   busy_r;
  logic              write_en_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;

  // Round-robin grant; readies are held low while reset is asserted
  always_comb begin
    alu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    if (rst) begin
      alu_gnt_s = alu_valid & (~lsu_valid | ptr_r);
      lsu_gnt_s = lsu_valid & (~alu_valid | ~ptr_r);
    end else begin
      alu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end
  end

  assign xfer_s    = alu_gnt_s | lsu_gnt_s;
  assign alu_ready = alu_gnt_s;
  assign lsu_ready = lsu_gnt_s;

  // Mux the granted requester onto the write path
  always_comb begin
    sel_rd_s   = lsu_rd;
    sel_data_s = lsu_data;
    if (alu_gnt_s) begin
      sel_rd_s   = alu_rd;
      sel_data_s = alu_data;
    end else begin
      sel_rd_s   = lsu_rd;
      sel_data_s = lsu_data;
    end
  end

  // Scoreboard next state: landing write clears, issue sets, and the set is applied last so it wins
  always_comb begin
    busy_nxt_s = busy_r;
    if (write_en_r) begin
      busy_nxt_s[waddr_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (issue_valid && (issue_rd != ZERO_IDX)) begin
      busy_nxt_s[issue_rd] = 1'b1;
    end else begin
      busy_nxt_s[issue_rd] = busy_nxt_s[issue_rd];
    end
  end

  // Arbitration pointer advances only on an accepted transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= 1'b1;
    end else if (alu_gnt_s) begin
      ptr_r <= 1'b0;
    end else if (lsu_gnt_s) begin
      ptr_r <= 1'b1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Registered write port; writes to x0 are accepted but never pulse write_en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en_r <= 1'b0;
      waddr_r    <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
    end else if (xfer_s) begin
      write_en_r <= (sel_rd_s != ZERO_IDX);
      waddr_r    <= sel_rd_s;
      wdata_r    <= sel_data_s;
    end else begin
      write_en_r <= 1'b0;
      waddr_r    <= waddr_r;
      wdata_r    <= wdata_r;
    end
  end

  // Busy vector register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Source lookups; a write landing this cycle to the same index is forwarded when bypass is built in
  always_comb begin
`ifdef WB_BYPASS_EN
    rs1_hit_s = write_en_r && (waddr_r == rs1) && (rs1 != ZERO_IDX);
    rs2_hit_s = write_en_r && (waddr_r == rs2) && (rs2 != ZERO_IDX);
`else
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
`endif
    rs1_busy_s = (rs1 != ZERO_IDX) ? (busy_r[rs1] & ~rs1_hit_s) : 1'b0;
    rs2_busy_s = (rs2 != ZERO_IDX) ? (busy_r[rs2] & ~rs2_hit_s) : 1'b0;
  end

  assign rs1_busy = rs1_busy_s;
  assign rs2_busy = rs2_busy_s;
  assign write_en = write_en_r;
  assign waddr    = waddr_r;
  assign wdata    = wdata_r;

`ifdef WB_BYPASS_EN
  assign rs1_fwd_hit = rs1_hit_s;
  assign rs2_fwd_hit = rs2_hit_s;
  assign rs1_fwd     = wdata_r;
  assign rs2_fwd     = wdata_r;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model (last-granted requester, busy array, expected write).
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] alu_rd, lsu_rd, issue_rd, rs1, rs2, waddr;
  logic [DW-1:0] alu_data, lsu_data, wdata;
  logic          issue_valid, rs1_busy, rs2_busy, write_en;
`ifdef WB_BYPASS_EN
  logic [DW-1:0] rs1_fwd, rs2_fwd;
  logic          rs1_fwd_hit, rs2_fwd_hit;
`endif

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  bit          m_last_lsu;
  bit          m_busy [NR];
  bit          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .write_en(write_en), .waddr(waddr), .wdata(wdata)
`ifdef WB_BYPASS_EN
    , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .rs1_fwd_hit(rs1_fwd_hit), .rs2_fwd_hit(rs2_fwd_hit)
`endif
  );

  // 0 = nobody, 1 = ALU, 2 = LSU
  function automatic int exp_winner();
    if (!rst) return 0;
    if (alu_valid && !lsu_valid) return 1;
    if (lsu_valid && !alu_valid) return 2;
    if (alu_valid && lsu_valid) return m_last_lsu ? 1 : 2;
    return 0;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] rs);
    if (rs == 0) return 1'b0;
`ifdef WB_BYPASS_EN
    if (m_we && m_waddr == rs) return 1'b0;
`endif
    return m_busy[rs];
  endfunction

  task automatic model_reset();
    m_last_lsu = 1'b1;
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied
  task automatic model_edge();
    int w;
    w = exp_winner();
    if (m_we) m_busy[m_waddr] = 1'b0;
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (w == 1) begin
      m_we = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data; m_last_lsu = 1'b0;
    end else if (w == 2) begin
      m_we = (lsu_rd != 0); m_waddr = lsu_rd; m_wdata = lsu_data; m_last_lsu = 1'b1;
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    alu_rd = '0; lsu_rd = '0; issue_rd = '0; rs1 = '0; rs2 = '0;
    alu_data = '0; lsu_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    alu_valid = 1; lsu_valid = 1; rs1 = 5'd4;
    model_reset();
    #3;
    n_total++; if (write_en !== 1'b0) $display("FAIL reset_we got=%b exp=0", write_en); else n_pass++;
    n_total++; if (waddr !== '0) $display("FAIL reset_waddr got=%0d exp=0", waddr); else n_pass++;
    n_total++; if (wdata !== '0) $display("FAIL reset_wdata got=%h exp=0", wdata); else n_pass++;
    n_total++; if ({alu_ready, lsu_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {alu_ready, lsu_ready}); else n_pass++;
    n_total++; if (rs1_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", rs1_busy); else n_pass++;
    @(negedge clk); idle_inputs(); rst = 1'b1;
  endtask

  task automatic test_alu_single();
    @(negedge clk);
    idle_inputs();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_total++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) $display("FAIL alu_single_ready got=%b%b exp=10", alu_ready, lsu_ready); else n_pass++;
    step();
    n_total++;
    if (write_en !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF)
      $display("FAIL alu_single_write got=%b/%0d/%h exp=1/5/deadbeef", write_en, waddr, wdata);
    else n_pass++;
    @(negedge clk); idle_inputs();
    #1;
    step();
    n_total++; if (write_en !== 1'b0) $display("FAIL alu_single_pulse got=%b exp=0", write_en); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_valid = 1; lsu_valid = 1;
      alu_rd = AW'(i + 1); lsu_rd = AW'(i + 9);
      alu_data = 32'hA000_0000 + i; lsu_data = 32'hB000_0000 + i;
      #1;
      n_total++;
      if (alu_ready !== (i % 2 == 0) || lsu_ready !== (i % 2 == 1))
        $display("FAIL rr_grant%0d got=%b%b exp_alu=%0d", i, alu_ready, lsu_ready, (i % 2 == 0));
      else n_pass++;
      step();
      n_total++;
      if (write_en !== 1'b1 || waddr !== ((i % 2 == 0) ? AW'(i + 1) : AW'(i + 9)) ||
          wdata !== ((i % 2 == 0) ? 32'hA000_0000 + i : 32'hB000_0000 + i))
        $display("FAIL rr_write%0d got=%b/%0d/%h", i, write_en, waddr, wdata);
      else n_pass++;
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_scoreboard();
    do_reset();
    @(negedge clk); issue_valid = 1; issue_rd = 5'd7;
    step();
    @(negedge clk); issue_valid = 0; rs1 = 5'd7;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h1234_5678;
    #1;
    n_total++; if (rs1_busy !== 1'b1) $display("FAIL sb_busy_set got=%b exp=1", rs1_busy); else n_pass++;
    step();
    @(negedge clk); alu_valid = 0;
    #1;
`ifdef WB_BYPASS_EN
    n_total++; if (rs1_busy !== 1'b0 || rs1_fwd_hit !== 1'b1 || rs1_fwd !== 32'h1234_5678)
      $display("FAIL sb_bypass got=%b/%b/%h exp=0/1/12345678", rs1_busy, rs1_fwd_hit, rs1_fwd);
    else n_pass++;
`else
    n_total++; if (rs1_busy !== 1'b1) $display("FAIL sb_busy_wcycle got=%b exp=1", rs1_busy); else n_pass++;
`endif
    step();
    n_total++; if (rs1_busy !== 1'b0) $display("FAIL sb_busy_clear got=%b exp=0", rs1_busy); else n_pass++;
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_rd_zero();
    @(negedge clk); idle_inputs();
    lsu_valid = 1; lsu_rd = '0; lsu_data = 32'hFFFF_0000;
    #1;
    n_total++; if (lsu_ready !== 1'b1) $display("FAIL rd0_ready got=%b exp=1", lsu_ready); else n_pass++;
    step();
    n_total++; if (write_en !== 1'b0) $display("FAIL rd0_we got=%b exp=0", write_en); else n_pass++;
    @(negedge clk); lsu_valid = 0; issue_valid = 1; issue_rd = '0;
    step();
    @(negedge clk); issue_valid = 0; rs1 = '0;
    #1;
    n_total++; if (rs1_busy !== 1'b0) $display("FAIL rd0_busy got=%b exp=0", rs1_busy); else n_pass++;
  endtask

  task automatic test_set_wins();
    @(negedge clk); idle_inputs(); issue_valid = 1; issue_rd = 5'd3;
    step();
    @(negedge clk); issue_valid = 0; alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
    step();
    @(negedge clk); alu_valid = 0; issue_valid = 1; issue_rd = 5'd3;
    step();
    @(negedge clk); issue_valid = 0; rs2 = 5'd3;
    #1;
    n_total++; if (rs2_busy !== 1'b1) $display("FAIL set_wins got=%b exp=1", rs2_busy); else n_pass++;
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      alu_valid = ($urandom_range(0, 9) < 6);
      lsu_valid = ($urandom_range(0, 9) < 6);
      alu_rd = AW'($urandom_range(0, 7)); lsu_rd = AW'($urandom_range(0, 7));
      alu_data = $urandom; lsu_data = $urandom;
      issue_valid = ($urandom_range(0, 9) < 3); issue_rd = AW'($urandom_range(0, 7));
      rs1 = AW'($urandom_range(0, 7)); rs2 = AW'($urandom_range(0, 31));
      #1;
      n_total++;
      if (alu_ready !== (exp_winner() == 1) || lsu_ready !== (exp_winner() == 2))
        $display("FAIL rnd_ready c=%0d got=%b%b exp_winner=%0d", c, alu_ready, lsu_ready, exp_winner());
      else n_pass++;
      n_total++;
      if (rs1_busy !== exp_busy(rs1) || rs2_busy !== exp_busy(rs2))
        $display("FAIL rnd_busy c=%0d got=%b%b exp=%b%b", c, rs1_busy, rs2_busy, exp_busy(rs1), exp_busy(rs2));
      else n_pass++;
      step();
      n_total++;
      if (write_en !== m_we || (m_we && (waddr !== m_waddr || wdata !== m_wdata)))
        $display("FAIL rnd_write c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, write_en, waddr, wdata, m_we, m_waddr, m_wdata);
      else n_pass++;
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); issue_valid = 1; issue_rd = 5'd9;
    step();
    @(negedge clk); issue_valid = 0; rs1 = 5'd9;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'hCAFE_F00D;
    step();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_total++; if (write_en !== 1'b0 || waddr !== '0 || wdata !== '0)
      $display("FAIL rstmid_out got=%b/%0d/%h exp=0/0/0", write_en, waddr, wdata);
    else n_pass++;
    n_total++; if (rs1_busy !== 1'b0 || alu_ready !== 1'b0)
      $display("FAIL rstmid_busy_ready got=%b/%b exp=0/0", rs1_busy, alu_ready);
    else n_pass++;
    @(negedge clk); idle_inputs();
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (write_en !== 1'b0) $display("FAIL rstmid_release%0d got=%b exp=0", i, write_en); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_round_robin();
    test_scoreboard();
    test_rd_zero();
    test_set_wins();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width (2**ADDR_W registers).
REQ-003 Port clk input 1: single clock; all state updates on rising edge.
REQ-004 Port rst input 1: asynchronous, active-low reset.
REQ-005 Port alu_valid/alu_ready input/output 1/1: ALU writeback request handshake.
REQ-006 Port alu_rd/alu_data input ADDR_W/DATA_W: ALU destination index and result.
REQ-007 Port lsu_valid/lsu_ready input/output 1/1: load-unit writeback request handshake.
REQ-008 Port lsu_rd/lsu_data input ADDR_W/DATA_W: load destination index and data.
REQ-009 Port issue_valid/issue_rd input 1/ADDR_W: decode issued an instruction that will write issue_rd.
REQ-010 Port rs1/rs2 input ADDR_W each: source indices being decoded.
REQ-011 Port rs1_busy/rs2_busy output 1 each: source has an outstanding write; decode stalls.
REQ-012 Port write_en/waddr/wdata output 1/ADDR_W/DATA_W: register-file write port drive.

Function
REQ-013 Transfer occurs on a requester when valid and ready are both high at a rising edge.
REQ-014 Ready SHALL be combinational from valid and the round-robin pointer; at most one ready high per cycle.
REQ-015 Single valid requester SHALL be granted the same cycle regardless of pointer.
REQ-016 Both valid: grant the requester not granted last; pointer (1 bit, 0=ALU last, 1=LSU last) updates only on a transfer.
REQ-017 Pointer reset value 1, so the first contended cycle grants ALU.
REQ-018 Granted transfer SHALL appear on write_en/waddr/wdata exactly one cycle later (registered outputs); write_en high for one cycle per transfer.
REQ-019 Transfer with rd == 0 SHALL be accepted (ready high) but produce write_en = 0; x0 never written.
REQ-020 Scoreboard: 2**ADDR_W-bit busy vector; bit issue_rd set on issue_valid when issue_rd != 0.
REQ-021 Busy bit waddr cleared on the edge after write_en is asserted (i.e., when the write lands).
REQ-022 Set and clear of the same bit on the same edge: set wins.
REQ-023 Issue to an already-busy index: bit stays set; one write clears it (no counting).
REQ-024 rsN_busy = busy[rsN]; index 0 always reports not busy.
REQ-025 No valid requester: no ready, write_en 0 next cycle, pointer unchanged.

Reset
REQ-026 On rst low, immediately and independent of clk: write_en 0, waddr 0, wdata 0, busy vector all 0, pointer 1, both readies 0.
REQ-027 Reset mid-transfer SHALL discard the pending registered write; no write_en pulse after release.
REQ-028 Normal operation resumes on the first rising edge with rst high.

Configuration
REQ-029 Macro WB_BYPASS_EN: when defined, ports rs1_fwd/rs2_fwd (DATA_W) and rs1_fwd_hit/rs2_fwd_hit (1) are added; when write_en is high and waddr == rsN != 0, rsN_fwd_hit = 1, rsN_fwd = wdata and rsN_busy = 0 that cycle.
REQ-030 Without WB_BYPASS_EN those ports do not exist and rsN_busy follows REQ-024 only.

Verification
REQ-031 ALU alone, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready same cycle; next cycle write_en=1, waddr=5, wdata=0xDEADBEEF.
REQ-032 ALU and LSU valid for 4 cycles after reset -> grants ALU, LSU, ALU, LSU; four consecutive write_en pulses in that order.
REQ-033 issue_rd=7, then rs1=7 -> rs1_busy=1 until edge after write to 7; rs1_busy=0 thereafter; with WB_BYPASS_EN, rs1_fwd_hit=1 and rs1_busy=0 in the write_en cycle.
REQ-034 LSU transfer with lsu_rd=0 -> lsu_ready=1, write_en stays 0; issue_rd=0 -> rs1_busy for rs1=0 stays 0.
REQ-035 issue_rd=3 on the same edge the write to 3 clears it -> busy[3] remains 1.
REQ-036 Assert rst low during cycle after ALU grant -> write_en, busy vector 0 immediately; no write_en after release.
